// File: rtl/off_mem_pkg.sv
// Shared types and constants for the off-chip memory arbiter.
// Requester ids, round-robin priority encoding and stall-counter width.
package off_mem_pkg;

   typedef logic req_id_t;

   localparam req_id_t REQ_HOST = 1'b0;
   localparam req_id_t REQ_CORE = 1'b1;

   typedef enum logic {
      PRI_HOST = 1'b0,
      PRI_CORE = 1'b1
   } pri_t;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants a lone requester outright, breaks ties
// with a priority pointer that moves to the other requester after any grant.
module rr_arb2
   import off_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       pri
);

   pri_t pri_q;
   pri_t pri_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         pri_q <= PRI_HOST;
      end else begin
         pri_q <= pri_nxt;
      end
   end

   always_comb begin
      gnt     = 2'b00;
      pri_nxt = pri_q;
      if (req == 2'b11) begin
         gnt = (pri_q == PRI_CORE) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
      if (gnt[0]) begin
         pri_nxt = PRI_CORE;
      end else if (gnt[1]) begin
         pri_nxt = PRI_HOST;
      end
   end

   assign pri = pri_q;

endmodule

// File: rtl/off_mem_arbiter.sv
// Shares a simple dual-port BRAM between host (r0) and core (r1), with
// independent round-robin write and read arbitration and tagged read return.
// Optional stall counters: define OFF_MEM_ARB_PERF_CNT_EN.
// Handshake: a requester holds req/we/addr/wdata until gnt; the op transfers
// in the cycle req & gnt; rvalid is a one-cycle pulse with no backpressure.
module off_mem_arbiter
   import off_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [DATA_WIDTH-1:0] r0_wdata,
   output logic                  r0_gnt,
   output logic                  r0_rvalid,
   output logic [DATA_WIDTH-1:0] r0_rdata,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [DATA_WIDTH-1:0] r1_wdata,
   output logic                  r1_gnt,
   output logic                  r1_rvalid,
   output logic [DATA_WIDTH-1:0] r1_rdata,
   output logic                  wea,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dina,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] doutb,
   output logic                  wr_ptr,
   output logic                  rd_ptr
`ifdef OFF_MEM_ARB_PERF_CNT_EN
  ,output logic [STALL_CNT_W-1:0] r0_stall_cnt,
   output logic [STALL_CNT_W-1:0] r1_stall_cnt
`endif
);

   logic [1:0] wr_req;
   logic [1:0] rd_req;
   logic [1:0] wr_gnt;
   logic [1:0] rd_gnt;

   // Masking requests during reset keeps every grant and BRAM enable low.
   assign wr_req = {r1_req & r1_we,  r0_req & r0_we}  & {2{~reset}};
   assign rd_req = {r1_req & ~r1_we, r0_req & ~r0_we} & {2{~reset}};

   rr_arb2 u_wr_arb (
      .clk   (clk),
      .reset (reset),
      .req   (wr_req),
      .gnt   (wr_gnt),
      .pri   (wr_ptr)
   );

   rr_arb2 u_rd_arb (
      .clk   (clk),
      .reset (reset),
      .req   (rd_req),
      .gnt   (rd_gnt),
      .pri   (rd_ptr)
   );

   assign r0_gnt = wr_gnt[0] | rd_gnt[0];
   assign r1_gnt = wr_gnt[1] | rd_gnt[1];

   assign wea   = |wr_gnt;
   assign addra = wr_gnt[1] ? r1_addr  : r0_addr;
   assign dina  = wr_gnt[1] ? r1_wdata : r0_wdata;
   assign enb   = |rd_gnt;
   assign addrb = rd_gnt[1] ? r1_addr  : r0_addr;

   // Tag pipeline tracks which requester owns the word leaving the BRAM.
   logic [RD_LATENCY-1:0] tag_v;
   logic [RD_LATENCY-1:0] tag_id;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         tag_v[0]  <= enb;
         tag_id[0] <= rd_gnt[1] ? REQ_CORE : REQ_HOST;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // A tag leaving the pipe in a reset cycle is dropped, not delivered.
   assign r0_rvalid = tag_v[RD_LATENCY-1] & ~reset & (tag_id[RD_LATENCY-1] == REQ_HOST);
   assign r1_rvalid = tag_v[RD_LATENCY-1] & ~reset & (tag_id[RD_LATENCY-1] == REQ_CORE);
   assign r0_rdata  = doutb;
   assign r1_rdata  = doutb;

`ifdef OFF_MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r0_stall_cnt <= '0;
         r1_stall_cnt <= '0;
      end else begin
         if (r0_req && !r0_gnt && (r0_stall_cnt != '1)) begin
            r0_stall_cnt <= r0_stall_cnt + STALL_CNT_W'(1);
         end
         if (r1_req && !r1_gnt && (r1_stall_cnt != '1)) begin
            r1_stall_cnt <= r1_stall_cnt + STALL_CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_off_mem_arbiter.sv
// Self-checking bench for off_mem_arbiter with a behavioural BRAM, a memory and
// round-robin reference model, and a read-return scoreboard.
module tb_off_mem_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          wea, enb;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina, doutb;
   logic          wr_ptr, rd_ptr;
`ifdef OFF_MEM_ARB_PERF_CNT_EN
   logic [15:0]   r0_stall_cnt, r1_stall_cnt;
`endif

   always #5 clk = ~clk;

   off_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .wea(wea), .addra(addra), .dina(dina),
      .enb(enb), .addrb(addrb), .doutb(doutb),
      .wr_ptr(wr_ptr), .rd_ptr(rd_ptr)
`ifdef OFF_MEM_ARB_PERF_CNT_EN
     ,.r0_stall_cnt(r0_stall_cnt), .r1_stall_cnt(r1_stall_cnt)
`endif
   );

   // Behavioural BRAM: read-first, LAT-cycle read pipe, cleared by clr_mem.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] bram_pipe [LAT];
   logic          clr_mem;

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      end else if (wea) begin
         mem[addra] <= dina;
      end
      if (enb) bram_pipe[0] <= mem[addrb];
      for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign doutb = bram_pipe[LAT-1];

   // Reference state
   logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
   logic          mdl_wr_ptr, mdl_rd_ptr;
   int            mdl_stall0, mdl_stall1;
   logic [DW:0]   exp_q[$];
   int            due_q[$];
   int            cyc_cnt;
   logic          last_g0, last_g1;
   int            n_checks, n_errors;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
      end
   endtask

   task automatic set_r0(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
   endtask

   task automatic set_r1(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
   endtask

   // One clock cycle: check outputs at negedge against the model, then advance.
   task automatic cyc();
      logic        wc0, wc1, rc0, rc1, ew0, ew1, er0, er1;
      logic [DW:0] ent;
      @(negedge clk);
      if (reset) begin
         exp_q.delete();
         due_q.delete();
      end
      if (exp_q.size() > 0 && due_q[0] == cyc_cnt) begin
         ent = exp_q.pop_front();
         void'(due_q.pop_front());
         check("r0_rvalid", r0_rvalid, !ent[DW]);
         check("r1_rvalid", r1_rvalid, ent[DW]);
         check("rdata", ent[DW] ? r1_rdata : r0_rdata, ent[DW-1:0]);
      end else begin
         check("r0_rvalid_idle", r0_rvalid, 0);
         check("r1_rvalid_idle", r1_rvalid, 0);
      end

      wc0 = !reset && r0_req && r0_we;
      wc1 = !reset && r1_req && r1_we;
      rc0 = !reset && r0_req && !r0_we;
      rc1 = !reset && r1_req && !r1_we;
      ew0 = wc0 && (!wc1 || !mdl_wr_ptr);
      ew1 = wc1 && (!wc0 || mdl_wr_ptr);
      er0 = rc0 && (!rc1 || !mdl_rd_ptr);
      er1 = rc1 && (!rc0 || mdl_rd_ptr);

      check("r0_gnt", r0_gnt, ew0 | er0);
      check("r1_gnt", r1_gnt, ew1 | er1);
      check("wea", wea, ew0 | ew1);
      check("enb", enb, er0 | er1);
      check("wr_ptr", wr_ptr, mdl_wr_ptr);
      check("rd_ptr", rd_ptr, mdl_rd_ptr);
      if (ew0 || ew1) begin
         check("addra", addra, ew1 ? r1_addr : r0_addr);
         check("dina", dina, ew1 ? r1_wdata : r0_wdata);
      end
      if (er0 || er1) check("addrb", addrb, er1 ? r1_addr : r0_addr);
`ifdef OFF_MEM_ARB_PERF_CNT_EN
      check("r0_stall_cnt", r0_stall_cnt, mdl_stall0);
      check("r1_stall_cnt", r1_stall_cnt, mdl_stall1);
`endif

      // Reads see memory before this cycle's write.
      if (er0) begin exp_q.push_back({1'b0, mdl_mem[r0_addr]}); due_q.push_back(cyc_cnt + LAT); end
      if (er1) begin exp_q.push_back({1'b1, mdl_mem[r1_addr]}); due_q.push_back(cyc_cnt + LAT); end
      if (ew0) mdl_mem[r0_addr] = r0_wdata;
      if (ew1) mdl_mem[r1_addr] = r1_wdata;

      if (reset) begin
         mdl_wr_ptr = 1'b0; mdl_rd_ptr = 1'b0;
         mdl_stall0 = 0;    mdl_stall1 = 0;
      end else begin
         if (ew0 || ew1) mdl_wr_ptr = ew0;
         if (er0 || er1) mdl_rd_ptr = er0;
         if (r0_req && !(ew0 | er0) && mdl_stall0 < 16'hFFFF) mdl_stall0++;
         if (r1_req && !(ew1 | er1) && mdl_stall1 < 16'hFFFF) mdl_stall1++;
      end
      last_g0 = ew0 | er0;
      last_g1 = ew1 | er1;
      @(posedge clk);
      cyc_cnt++;
      #1;
   endtask

   task automatic idle(input int n);
      set_r0(0, 0, '0, '0);
      set_r1(0, 0, '0, '0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      n_checks = 0; n_errors = 0; cyc_cnt = 0;
      mdl_wr_ptr = 1'b0; mdl_rd_ptr = 1'b0;
      mdl_stall0 = 0; mdl_stall1 = 0;
      last_g0 = 1'b0; last_g1 = 1'b0;
      for (int i = 0; i < (1<<AW); i++) mdl_mem[i] = '0;
      reset = 1'b1; clr_mem = 1'b1;
      set_r0(0, 0, '0, '0);
      set_r1(0, 0, '0, '0);
      cyc();
      // Requests held during reset must not be granted.
      set_r0(1, 1, 8'h01, 32'h1);
      set_r1(1, 0, 8'h02, 32'h0);
      cyc();
      reset = 1'b0; clr_mem = 1'b0;
      idle(1);

      // Write contention: grants alternate r0, r1, ...
      set_r0(1, 1, 8'h10, 32'hAAAA_0000);
      set_r1(1, 1, 8'h20, 32'hBBBB_0000);
      for (int i = 0; i < 6; i++) begin
         cyc();
         check("contention_order", {last_g1, last_g0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      idle(1);

      // Read after write
      set_r0(1, 1, 8'h05, 32'h1234_5678);
      cyc();
      set_r0(1, 0, 8'h05, '0);
      cyc();
      idle(LAT + 2);

      // Parallel write and read from different requesters
      set_r1(1, 1, 8'h07, 32'h0000_CAFE);
      cyc();
      set_r0(1, 1, 8'h33, 32'h33);
      set_r1(1, 0, 8'h07, '0);
      cyc();
      check("parallel_both_gnt", {last_g1, last_g0}, 2'b11);
      idle(LAT + 2);

      // Same-address collision: read-first
      set_r1(1, 1, 8'h09, 32'h1);
      cyc();
      set_r0(1, 1, 8'h09, 32'h2);
      set_r1(1, 0, 8'h09, '0);
      cyc();
      set_r0(0, 0, '0, '0);
      cyc();
      cyc();
      idle(LAT + 2);

      // Reset with a read in flight
      set_r0(1, 0, 8'h05, '0);
      cyc();
      reset = 1'b1;
      set_r1(1, 1, 8'h0A, 32'h5);
      cyc();
      reset = 1'b0;
      set_r0(1, 0, 8'h05, '0);
      set_r1(1, 0, 8'h07, '0);
      cyc();
      check("post_reset_rd_r0_first", {last_g1, last_g0}, 2'b01);
      idle(LAT + 2);

`ifdef OFF_MEM_ARB_PERF_CNT_EN
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      set_r0(1, 0, 8'h05, '0);
      set_r1(1, 0, 8'h07, '0);
      for (int i = 0; i < 10; i++) cyc();
      check("perf_r0_stall", r0_stall_cnt, 5);
      check("perf_r1_stall", r1_stall_cnt, 5);
      idle(LAT + 2);
`endif

      // Random traffic; each requester holds its op until granted.
      set_r0(0, 0, '0, '0);
      set_r1(0, 0, '0, '0);
      for (int i = 0; i < 60; i++) begin
         if (!r0_req || last_g0)
            set_r0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
         if (!r1_req || last_g1)
            set_r1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
         cyc();
      end
      idle(LAT + 3);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
